lsu_ctrl: RTL and testbench

//  Load/store unit controller. Consumes the mem_read/mem_write decode from the control unit.

---
 rtl/riscv_pkg.sv | 31 +++
 rtl/lsu_align.sv | 51 +++++
 rtl/lsu_ctrl.sv | 165 ++++++++++++++++
 tb/tb_lsu_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions used by the load/store unit: funct3 access codes,
// LSU FSM state encoding, opcode constants and small decode helpers.
package riscv_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_REQ      = 2'd1,
      ST_WAIT_RSP = 2'd2
   } lsu_state_e;

   function automatic logic f3_legal(input logic [2:0] f3);
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
             (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

   // Halfword needs addr[0]==0, word needs addr[1:0]==0.
   function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] a);
      return (((f3 == F3_H) || (f3 == F3_HU)) && a[0]) ||
             ((f3 == F3_W) && (a != 2'b00));
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the LSU: store byte-lane replication and strobes,
// load lane select with sign/zero extension. Size/sign come from funct3.
module lsu_align
   import riscv_pkg::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_st_data,
   input  logic [31:0] i_ld_word,
   output logic [31:0] o_st_data,
   output logic [3:0]  o_st_strb,
   output logic [31:0] o_ld_data
);

   logic [31:0] w_shifted;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic        w_unsigned;

   always_comb begin
      w_shifted  = i_ld_word >> {i_addr_lo, 3'b000};
      w_byte     = w_shifted[7:0];
      w_half     = i_addr_lo[1] ? i_ld_word[31:16] : i_ld_word[15:0];
      w_unsigned = i_funct3[2];
   end

   // funct3[1:0] carries the size; bit 2 only selects zero extension on loads.
   always_comb begin
      o_st_data = i_st_data;
      o_st_strb = 4'b1111;
      o_ld_data = i_ld_word;
      case (i_funct3[1:0])
         2'b00: begin
            o_st_data = {4{i_st_data[7:0]}};
            o_st_strb = 4'b0001 << i_addr_lo;
            o_ld_data = w_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
         end
         2'b01: begin
            o_st_data = {2{i_st_data[15:0]}};
            o_st_strb = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            o_ld_data = w_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
         end
         default: begin
            o_st_data = i_st_data;
            o_st_strb = 4'b1111;
            o_ld_data = i_ld_word;
         end
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: valid/ready request + response handshake with data
// memory, pipeline stall, load write-back. Build macro: LSU_MISALIGN_TRAP_EN.
//
// state       | meaning
// ------------+----------------------------------------------------------
// ST_IDLE     | no access in flight; accepts mem_read ^ mem_write
// ST_REQ      | dmem_req_valid high, request fields held until ready
// ST_WAIT_RSP | load accepted by memory, waiting for dmem_rsp_valid
module lsu_ctrl
   import riscv_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [4:0]  rd_in,
   output logic        stall,
   output logic        load_valid,
   output logic [31:0] load_data,
   output logic [4:0]  rd_out,
   output logic        bus_err,
   output logic        misaligned,
   output logic        dmem_req_valid,
   input  logic        dmem_req_ready,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_wstrb,
   input  logic        dmem_rsp_valid,
   input  logic [31:0] dmem_rdata
);

   localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TC_LAST = CW'(TIMEOUT_CYCLES - 1);

   lsu_state_e  r_state;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [2:0]  r_funct3;
   logic [4:0]  r_rd;
   logic        r_we;
   logic [CW-1:0] r_cnt;
   logic        r_load_valid;
   logic [31:0] r_load_data;
   logic [4:0]  r_rd_out;
   logic        r_bus_err;
   logic        r_misaligned;

   logic        w_idle;
   logic        w_start;
   logic        w_both;
   logic        w_misal;
   logic        w_timeout;
   logic        w_in_req;
   logic [31:0] w_st_data;
   logic [3:0]  w_st_strb;
   logic [31:0] w_ld_data;

   assign w_idle    = (r_state == ST_IDLE);
   assign w_start   = w_idle & (mem_read ^ mem_write);
   assign w_both    = w_idle & mem_read & mem_write;
   assign w_in_req  = (r_state == ST_REQ);
   assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == TC_LAST);

`ifdef LSU_MISALIGN_TRAP_EN
   assign w_misal = f3_misaligned(funct3, addr[1:0]);
`else
   assign w_misal = 1'b0;
`endif

   lsu_align u_align (
      .i_funct3  (r_funct3),
      .i_addr_lo (r_addr[1:0]),
      .i_st_data (r_wdata),
      .i_ld_word (dmem_rdata),
      .o_st_data (w_st_data),
      .o_st_strb (w_st_strb),
      .o_ld_data (w_ld_data)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_funct3     <= '0;
         r_rd         <= '0;
         r_we         <= 1'b0;
         r_cnt        <= '0;
         r_load_valid <= 1'b0;
         r_load_data  <= '0;
         r_rd_out     <= '0;
         r_bus_err    <= 1'b0;
         r_misaligned <= 1'b0;
      end else begin
         r_load_valid <= 1'b0;
         r_bus_err    <= 1'b0;
         r_misaligned <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_both) begin
                  r_bus_err <= 1'b1;
               end else if (w_start) begin
                  if (!f3_legal(funct3)) begin
                     r_bus_err <= 1'b1;
                  end else if (w_misal) begin
                     r_misaligned <= 1'b1;
                  end else begin
                     r_addr   <= addr;
                     r_wdata  <= wdata;
                     r_funct3 <= funct3;
                     r_rd     <= rd_in;
                     r_we     <= mem_write;
                     r_cnt    <= '0;
                     r_state  <= ST_REQ;
                  end
               end
            end
            // A handshake in the last allowed cycle still completes.
            ST_REQ: begin
               r_cnt <= r_cnt + 1'b1;
               if (dmem_req_ready) begin
                  r_state <= r_we ? ST_IDLE : ST_WAIT_RSP;
               end else if (w_timeout) begin
                  r_bus_err <= 1'b1;
                  r_state   <= ST_IDLE;
               end
            end
            ST_WAIT_RSP: begin
               r_cnt <= r_cnt + 1'b1;
               if (dmem_rsp_valid) begin
                  r_load_valid <= 1'b1;
                  r_load_data  <= w_ld_data;
                  r_rd_out     <= r_rd;
                  r_state      <= ST_IDLE;
               end else if (w_timeout) begin
                  r_bus_err <= 1'b1;
                  r_state   <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign stall          = w_start | ~w_idle;
   assign load_valid     = r_load_valid;
   assign load_data      = r_load_data;
   assign rd_out         = r_rd_out;
   assign bus_err        = r_bus_err;
   assign misaligned     = r_misaligned;

   // Request fields are forced to zero outside ST_REQ so the bus sees no stale lanes.
   assign dmem_req_valid = w_in_req;
   assign dmem_we        = w_in_req & r_we;
   assign dmem_addr      = w_in_req ? {r_addr[31:2], 2'b00} : 32'd0;
   assign dmem_wdata     = (w_in_req & r_we) ? w_st_data : 32'd0;
   assign dmem_wstrb     = (w_in_req & r_we) ? w_st_strb : 4'd0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl, built with TIMEOUT_CYCLES=4.
module tb_lsu_ctrl;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_read, mem_write;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata;
   logic [4:0]  rd_in;
   logic        stall, load_valid, bus_err, misaligned;
   logic [31:0] load_data;
   logic [4:0]  rd_out;
   logic        dmem_req_valid, dmem_req_ready, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_wstrb;
   logic        dmem_rsp_valid;
   logic [31:0] dmem_rdata;

   int n_checks = 0;
   int n_err    = 0;
   int hs_cnt   = 0;
   int hs_base;

   always #5 clk = ~clk;

   always @(posedge clk) if (dmem_req_valid && dmem_req_ready) hs_cnt <= hs_cnt + 1;

   lsu_ctrl #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
      .funct3(funct3), .addr(addr), .wdata(wdata), .rd_in(rd_in),
      .stall(stall), .load_valid(load_valid), .load_data(load_data), .rd_out(rd_out),
      .bus_err(bus_err), .misaligned(misaligned),
      .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
      .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Load with one empty WAIT_RSP cycle before the response.
   task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] rdata, input logic [4:0] rd,
                          input logic [31:0] exp);
      mem_read = 1'b1; funct3 = f3; addr = a; rd_in = rd; dmem_req_ready = 1'b1;
      #1 chk({tag, "_stall_start"}, stall, 1);
      tick();
      mem_read = 1'b0;
      chk({tag, "_req_valid"}, dmem_req_valid, 1);
      chk({tag, "_req_addr"}, dmem_addr, {a[31:2], 2'b00});
      chk({tag, "_req_we"}, dmem_we, 0);
      tick();
      chk({tag, "_wait_stall"}, stall, 1);
      chk({tag, "_wait_novalid"}, dmem_req_valid, 0);
      tick();
      dmem_rsp_valid = 1'b1; dmem_rdata = rdata;
      tick();
      dmem_rsp_valid = 1'b0;
      chk({tag, "_load_valid"}, load_valid, 1);
      chk({tag, "_load_data"}, load_data, exp);
      chk({tag, "_rd_out"}, rd_out, rd);
      chk({tag, "_stall_done"}, stall, 0);
      tick();
      chk({tag, "_pulse_end"}, load_valid, 0);
   endtask

   task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] exp_strb,
                           input logic [31:0] exp_wdata);
      mem_write = 1'b1; funct3 = f3; addr = a; wdata = wd; dmem_req_ready = 1'b1;
      tick();
      mem_write = 1'b0;
      chk({tag, "_req_valid"}, dmem_req_valid, 1);
      chk({tag, "_we"}, dmem_we, 1);
      chk({tag, "_addr"}, dmem_addr, {a[31:2], 2'b00});
      chk({tag, "_wstrb"}, dmem_wstrb, exp_strb);
      chk({tag, "_wdata"}, dmem_wdata, exp_wdata);
      tick();
      chk({tag, "_done_valid"}, dmem_req_valid, 0);
      chk({tag, "_done_stall"}, stall, 0);
      chk({tag, "_no_load"}, load_valid, 0);
   endtask

   initial begin
      rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
      addr = '0; wdata = '0; rd_in = '0; dmem_req_ready = 1'b0;
      dmem_rsp_valid = 1'b0; dmem_rdata = '0;
      tick(); tick();
      chk("rst_stall", stall, 0);
      chk("rst_req_valid", dmem_req_valid, 0);
      chk("rst_load_valid", load_valid, 0);
      chk("rst_load_data", load_data, 0);
      chk("rst_bus_err", bus_err, 0);
      chk("rst_wstrb", dmem_wstrb, 0);
      rst_n = 1'b1;
      tick();

      do_load("lw",  F3_W,  32'h100, 32'hDEADBEEF, 5'd5,  32'hDEADBEEF);
      do_load("lb",  F3_B,  32'h103, 32'h80FFFF7F, 5'd7,  32'hFFFFFF80);
      do_load("lbu", F3_BU, 32'h103, 32'h80FFFF7F, 5'd8,  32'h00000080);
      do_load("lhu", F3_HU, 32'h102, 32'h80FFFF7F, 5'd9,  32'h000080FF);
      do_load("lh",  F3_H,  32'h102, 32'h80FFFF7F, 5'd10, 32'hFFFF80FF);

      do_store("sb", F3_B, 32'h201, 32'h000000AB, 4'b0010, 32'hABABABAB);
      do_store("sh", F3_H, 32'h202, 32'h00001234, 4'b1100, 32'h12341234);
      do_store("sw", F3_W, 32'h204, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D);

      // Ready held low for three REQ cycles, accepted in the fourth.
      hs_base = hs_cnt;
      mem_write = 1'b1; funct3 = F3_W; addr = 32'h300; wdata = 32'h01234567;
      dmem_req_ready = 1'b0;
      tick();
      mem_write = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'h0;
      for (int i = 0; i < 3; i++) begin
         chk("hold_valid", dmem_req_valid, 1);
         chk("hold_addr", dmem_addr, 32'h300);
         chk("hold_wdata", dmem_wdata, 32'h01234567);
         chk("hold_stall", stall, 1);
         tick();
      end
      dmem_req_ready = 1'b1;
      chk("hold_last_valid", dmem_req_valid, 1);
      tick();
      chk("hold_done_valid", dmem_req_valid, 0);
      chk("hold_no_buserr", bus_err, 0);
      chk("hold_one_hs", hs_cnt - hs_base, 1);

      // Load with no response: bus_err after four busy cycles.
      mem_read = 1'b1; funct3 = F3_W; addr = 32'h400; rd_in = 5'd3;
      tick();
      mem_read = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("to_busy_err", bus_err, 0);
         chk("to_busy_stall", stall, 1);
         tick();
      end
      chk("to_last_err", bus_err, 0);
      tick();
      chk("to_bus_err", bus_err, 1);
      chk("to_stall_drop", stall, 0);
      chk("to_no_load", load_valid, 0);
      dmem_rsp_valid = 1'b1; dmem_rdata = 32'h11111111;
      tick();
      dmem_rsp_valid = 1'b0;
      chk("to_err_pulse", bus_err, 0);
      chk("to_late_rsp", load_valid, 0);
      do_load("lw2", F3_W, 32'h500, 32'h5A5A0F0F, 5'd12, 32'h5A5A0F0F);

      // Read and write together: error, no access, no stall.
      mem_read = 1'b1; mem_write = 1'b1; funct3 = F3_W; addr = 32'h600;
      #1 chk("both_stall", stall, 0);
      tick();
      mem_read = 1'b0; mem_write = 1'b0;
      chk("both_err", bus_err, 1);
      chk("both_noreq", dmem_req_valid, 0);
      tick();
      chk("both_err_end", bus_err, 0);

      // Unsupported funct3.
      mem_read = 1'b1; funct3 = 3'b011; addr = 32'h700;
      #1 chk("f3_stall", stall, 1);
      tick();
      mem_read = 1'b0;
      chk("f3_err", bus_err, 1);
      chk("f3_noreq", dmem_req_valid, 0);
      tick();
      chk("f3_stall_end", stall, 0);

      // Reset while waiting for a load response.
      mem_read = 1'b1; funct3 = F3_W; addr = 32'h800; rd_in = 5'd4; dmem_req_ready = 1'b1;
      tick();
      mem_read = 1'b0;
      tick();
      rst_n = 1'b0;
      tick();
      chk("rstw_stall", stall, 0);
      chk("rstw_req", dmem_req_valid, 0);
      chk("rstw_load_data", load_data, 0);
      chk("rstw_rd_out", rd_out, 0);
      rst_n = 1'b1;
      dmem_rsp_valid = 1'b1; dmem_rdata = 32'h22222222;
      tick();
      dmem_rsp_valid = 1'b0;
      chk("rstw_no_load", load_valid, 0);

`ifdef LSU_MISALIGN_TRAP_EN
      hs_base = hs_cnt;
      mem_read = 1'b1; funct3 = F3_H; addr = 32'h101;
      #1 chk("mis_stall", stall, 1);
      tick();
      mem_read = 1'b0;
      chk("mis_pulse", misaligned, 1);
      chk("mis_noreq", dmem_req_valid, 0);
      tick();
      chk("mis_end", misaligned, 0);
      chk("mis_no_hs", hs_cnt - hs_base, 0);
`else
      do_load("lh_odd", F3_H, 32'h101, 32'h80FFFF7F, 5'd11, 32'hFFFFFF7F);
      chk("mis_tied", misaligned, 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
